// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: definitions shared by the SPI init sequencer and its shifter.
//   state_e    : sequencer FSM states
//   SEL_*      : spi_sel route encodings
//   TBL_*      : tbl_data field bit positions and total width
//   frame_word : builds the 16-bit MOSI frame from a table entry
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_TAIL,
        ST_GAP,
        ST_CHECK,
        ST_FIN
    } state_e;

    localparam logic [1:0] SEL_HOST = 2'd0;
    localparam logic [1:0] SEL_RFIC = 2'd1;
    localparam logic [1:0] SEL_ADC1 = 2'd2;
    localparam logic [1:0] SEL_ADC2 = 2'd3;

    localparam int unsigned TBL_W       = 20;
    localparam int unsigned TBL_LAST    = 19;
    localparam int unsigned TBL_VERIFY  = 18;
    localparam int unsigned TBL_SEL_HI  = 17;
    localparam int unsigned TBL_SEL_LO  = 16;
    localparam int unsigned TBL_RW      = 15;
    localparam int unsigned TBL_ADDR_HI = 14;
    localparam int unsigned TBL_ADDR_LO = 8;
    localparam int unsigned TBL_DATA_HI = 7;
    localparam int unsigned TBL_DATA_LO = 0;

    // Reads carry a zero data field; the slave drives MISO during that byte.
    function automatic logic [15:0] frame_word(input logic       rw,
                                               input logic [6:0] addr,
                                               input logic [7:0] data);
        return {rw, addr, (rw ? 8'h00 : data)};
    endfunction

endpackage

// File: rtl/spi_seq_shifter.sv
// spi_seq_shifter: SPI mode-0 frame engine for one 16-bit frame.
//   clk, reset_n      : system clock, async active-low reset
//   go                : load frame {rw, addr, data} and start clocking
//   rw, addr, data    : frame fields (data replaced by zero on reads)
//   miso              : serial data in, sampled on rising sck
//   sck, mosi         : serial clock and data out
//   rx_byte           : MISO samples of bits 8..15, MSB first
//   last_edge         : high in the cycle whose clock edge makes the final sck fall
module spi_seq_shifter
    import spi_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       last_edge
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic        run_q,  run_d;
    logic        sck_q,  sck_d;
    logic        mosi_q, mosi_d;
    logic [15:0] sh_q,   sh_d;
    logic [7:0]  div_q,  div_d;
    logic [4:0]  hp_q,   hp_d;
    logic [7:0]  rx_q,   rx_d;
    logic        tick;

    assign tick      = run_q && (div_q == DIV_LAST);
    assign last_edge = tick && (hp_q == 5'd31);

    always_comb begin
        run_d  = run_q;
        sck_d  = sck_q;
        mosi_d = mosi_q;
        sh_d   = sh_q;
        div_d  = div_q;
        hp_d   = hp_q;
        rx_d   = rx_q;
        if (go) begin
            sh_d   = frame_word(rw, addr, data);
            mosi_d = sh_d[15];
            run_d  = 1'b1;
            sck_d  = 1'b0;
            div_d  = '0;
            hp_d   = '0;
            rx_d   = '0;
        end else if (run_q) begin
            if (tick) begin
                div_d = '0;
                sck_d = ~sck_q;
                hp_d  = hp_q + 5'd1;
                if (!sck_q) begin
                    // Rising edge: hp_q[4] set means bit index 8..15.
                    if (hp_q[4]) begin
                        rx_d = {rx_q[6:0], miso};
                    end
                end else if (hp_q == 5'd31) begin
                    run_d  = 1'b0;
                    mosi_d = 1'b0;
                end else begin
                    sh_d   = {sh_q[14:0], 1'b0};
                    mosi_d = sh_q[14];
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q  <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            sh_q   <= '0;
            div_q  <= '0;
            hp_q   <= '0;
            rx_q   <= '0;
        end else begin
            run_q  <= run_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
            sh_q   <= sh_d;
            div_q  <= div_d;
            hp_q   <= hp_d;
            rx_q   <= rx_d;
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign rx_byte = rx_q;

endmodule

// File: rtl/spi_init_seq.sv
// spi_init_seq: walks an init table and issues one SPI frame per entry.
//   clk, reset_n      : system clock, async active-low reset
//   start, abort      : begin sequence / stop after the current frame
//   busy, done, err   : run status, end pulse, sticky readback mismatch
//   tbl_addr/tbl_data : synchronous table port (1-cycle read latency)
//   spi_sel           : slave route, changed only while m_csn is high
//   m_sck/m_csn/m_mosi/m_miso : master SPI lines
//   rd_data, rd_valid : captured read byte and its one-cycle strobe
module spi_init_seq
    import spi_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 3,
    parameter int unsigned TBL_AW  = 5,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [TBL_W-1:0]  tbl_data,
    output logic [1:0]        spi_sel,
    output logic              m_sck,
    output logic              m_csn,
    output logic              m_mosi,
    input  logic              m_miso,
    output logic [7:0]        rd_data,
    output logic              rd_valid
);

    localparam logic [15:0] TAIL_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

    state_e            state_q,    state_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
    logic [1:0]        spi_sel_q,  spi_sel_d;
    logic              csn_q,      csn_d;
    logic [7:0]        rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              abort_q,    abort_d;
    logic              ready_q,    ready_d;
    logic              load_ph_q,  load_ph_d;
    logic [15:0]       cnt_q,      cnt_d;
    logic              last_q,     last_d;
    logic              verify_q,   verify_d;
    logic              rw_q,       rw_d;
    logic [6:0]        addr_q,     addr_d;
    logic [7:0]        data_q,     data_d;

    logic       go;
    logic       last_edge;
    logic [7:0] rx_byte;

    // Second LOAD cycle: spi_sel has settled for a cycle, now drop CSN.
    assign go = (state_q == ST_LOAD) && load_ph_q;

    spi_seq_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .go        (go),
        .rw        (rw_q),
        .addr      (addr_q),
        .data      (data_q),
        .miso      (m_miso),
        .sck       (m_sck),
        .mosi      (m_mosi),
        .rx_byte   (rx_byte),
        .last_edge (last_edge)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        tbl_addr_d = tbl_addr_q;
        spi_sel_d  = spi_sel_q;
        csn_d      = csn_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        abort_d    = abort_q;
        ready_d    = 1'b1;
        load_ph_d  = load_ph_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        verify_d   = verify_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;

        if (busy_q && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // ready_q masks the first clk after reset release.
                if (start && ready_q) begin
                    err_d      = 1'b0;
                    tbl_addr_d = '0;
                    busy_d     = 1'b1;
                    abort_d    = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                load_ph_d = 1'b0;
                state_d   = ST_LOAD;
            end
            ST_LOAD: begin
                if (!load_ph_q) begin
                    last_d    = tbl_data[TBL_LAST];
                    verify_d  = tbl_data[TBL_VERIFY];
                    rw_d      = tbl_data[TBL_RW];
                    addr_d    = tbl_data[TBL_ADDR_HI:TBL_ADDR_LO];
                    data_d    = tbl_data[TBL_DATA_HI:TBL_DATA_LO];
                    spi_sel_d = tbl_data[TBL_SEL_HI:TBL_SEL_LO];
                    load_ph_d = 1'b1;
                end else begin
                    csn_d     = 1'b0;
                    load_ph_d = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_edge) begin
                    cnt_d   = '0;
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    csn_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                    if (rw_q) begin
                        rd_data_d  = rx_byte;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_CHECK: begin
                if (verify_q && rw_q && (rd_data_q != data_q)) begin
                    err_d = 1'b1;
                end
                if (last_q || (tbl_addr_q == '1) || abort_q || abort) begin
                    state_d = ST_FIN;
                end else begin
                    tbl_addr_d = tbl_addr_q + TBL_AW'(1);
                    state_d    = ST_FETCH;
                end
            end
            ST_FIN: begin
                busy_d    = 1'b0;
                done_d    = 1'b1;
                spi_sel_d = SEL_HOST;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tbl_addr_q <= '0;
            spi_sel_q  <= SEL_HOST;
            csn_q      <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            abort_q    <= 1'b0;
            ready_q    <= 1'b0;
            load_ph_q  <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            verify_q   <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tbl_addr_q <= tbl_addr_d;
            spi_sel_q  <= spi_sel_d;
            csn_q      <= csn_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            abort_q    <= abort_d;
            ready_q    <= ready_d;
            load_ph_q  <= load_ph_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            verify_q   <= verify_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tbl_addr = tbl_addr_q;
    assign spi_sel  = spi_sel_q;
    assign m_csn    = csn_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_spi_init_seq.sv
// tb_spi_init_seq: directed bench for spi_init_seq (defaults) plus a
// second instance with TBL_AW=2 for the no-last-bit table walk.
module tb_spi_init_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, err;
    logic [4:0]  tbl_addr;
    logic [19:0] tbl_data = '0;
    logic [1:0]  spi_sel;
    logic        m_sck, m_csn, m_mosi;
    logic        m_miso = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;

    logic        start2 = 1'b0;
    logic        busy2, done2, err2;
    logic [1:0]  tbl_addr2;
    logic [19:0] tbl_data2 = '0;
    logic [1:0]  spi_sel2;
    logic        m_sck2, m_csn2, m_mosi2;
    logic [7:0]  rd_data2;
    logic        rd_valid2;

    int errors = 0;
    int checks = 0;

    logic [19:0] tbl_mem  [0:31];
    logic [19:0] tbl2_mem [0:3];

    always #5 clk = ~clk;

    spi_init_seq #(.CLK_DIV(3), .TBL_AW(5), .CS_GAP(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .spi_sel(spi_sel), .m_sck(m_sck),
        .m_csn(m_csn), .m_mosi(m_mosi), .m_miso(m_miso),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    spi_init_seq #(.CLK_DIV(3), .TBL_AW(2), .CS_GAP(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0),
        .busy(busy2), .done(done2), .err(err2), .tbl_addr(tbl_addr2),
        .tbl_data(tbl_data2), .spi_sel(spi_sel2), .m_sck(m_sck2),
        .m_csn(m_csn2), .m_mosi(m_mosi2), .m_miso(1'b0),
        .rd_data(rd_data2), .rd_valid(rd_valid2)
    );

    always @(posedge clk) tbl_data  <= tbl_mem[tbl_addr];
    always @(posedge clk) tbl_data2 <= tbl2_mem[tbl_addr2];

    // Slave model: collects MOSI frames, answers 8'h3C to a read of 7'h07.
    int          rise_cnt = 0, fall_cnt = 0;
    logic [15:0] rx_frame = '0;
    logic [7:0]  sreg = '0;
    logic [15:0] frame_log[$];
    int          edge_log[$];
    logic [1:0]  sel_log[$];

    always @(negedge m_csn) begin
        rise_cnt = 0;
        fall_cnt = 0;
        sel_log.push_back(spi_sel);
    end
    always @(posedge m_sck) begin
        rx_frame = {rx_frame[14:0], m_mosi};
        rise_cnt++;
    end
    always @(negedge m_sck) begin
        fall_cnt++;
        if (fall_cnt == 8)
            sreg = (rx_frame[7] && rx_frame[6:0] == 7'h07) ? 8'h3C : 8'h00;
        if (fall_cnt >= 8 && fall_cnt < 16) m_miso = sreg[15 - fall_cnt];
        else m_miso = 1'b0;
    end
    always @(posedge m_csn) begin
        frame_log.push_back(rx_frame);
        edge_log.push_back(rise_cnt + fall_cnt);
    end

    // Cycle sampler (opposite edge) for timing and protocol observations.
    int         done_cnt = 0, rv_cnt = 0, sel_viol = 0, mosi_viol = 0;
    int         lead = 0, lead_log = 0, low_run = 0, low_log = 0;
    int         hi_run = 0, min_gap = 9999, csn_falls = 0;
    bit         seen_rise = 1'b0;
    logic [7:0] last_rd = '0;
    logic       prev_csn = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [1:0] prev_sel = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (done) done_cnt++;
            if (rd_valid) begin
                rv_cnt++;
                last_rd = rd_data;
            end
            if (spi_sel !== prev_sel && (!m_csn || !prev_csn)) sel_viol++;
            if (m_mosi !== prev_mosi && !m_csn && !prev_csn && !(prev_sck && !m_sck))
                mosi_viol++;
            if (!m_csn) begin
                if (prev_csn) begin
                    if (csn_falls > 0 && hi_run < min_gap) min_gap = hi_run;
                    csn_falls++;
                    lead = 0;
                    seen_rise = 1'b0;
                    low_run = 0;
                end
                low_run++;
                if (!seen_rise) begin
                    if (m_sck) begin
                        seen_rise = 1'b1;
                        lead_log = lead;
                    end else lead++;
                end
                hi_run = 0;
            end else begin
                if (!prev_csn) low_log = low_run;
                hi_run++;
            end
        end
        prev_csn  = reset_n ? m_csn : 1'b1;
        prev_sck  = reset_n ? m_sck : 1'b0;
        prev_mosi = reset_n ? m_mosi : 1'b0;
        prev_sel  = reset_n ? spi_sel : 2'd0;
    end

    int         frames2 = 0, done2_cnt = 0, wrap2 = 0;
    logic [1:0] addr2_at_done = '0, prev_addr2 = '0;
    logic       prev_csn2 = 1'b1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_csn2 && !m_csn2) frames2++;
            if (done2) begin
                done2_cnt++;
                addr2_at_done = tbl_addr2;
            end
            if (busy2 && prev_addr2 == 2'd3 && tbl_addr2 == 2'd0) wrap2++;
        end
        prev_csn2  = reset_n ? m_csn2 : 1'b1;
        prev_addr2 = tbl_addr2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] ent(input logic last, input logic verify,
                                        input logic [1:0] sel, input logic rw,
                                        input logic [6:0] addr, input logic [7:0] data);
        return {last, verify, sel, rw, addr, data};
    endfunction

    task automatic clear_logs();
        @(posedge clk);
        frame_log.delete();
        edge_log.delete();
        sel_log.delete();
        done_cnt = 0; rv_cnt = 0; sel_viol = 0; mosi_viol = 0;
        min_gap = 9999; csn_falls = 0; lead_log = 0; low_log = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done, expected done within 4000 cycles", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        logic [21:0] exp_v;
        exp_v = {1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {busy, done, err, tbl_addr, spi_sel, m_sck, m_csn, m_mosi, rd_data, rd_valid};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_values: got %h, expected %h", obs, exp_v);
        end
        // Start landing on the first clk after release must be ignored.
        reset_n = 1'b1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_first_clk_ignored: busy got %b, expected 0", busy);
        end
        obs = {busy, done, err, tbl_addr, spi_sel, m_sck, m_csn, m_mosi, rd_data, rd_valid};
        checks++;
        if (obs !== exp_v || m_csn2 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_values: got %h csn2=%b, expected %h csn2=1", obs, m_csn2, exp_v);
        end
    endtask

    task automatic test_single_write();
        tbl_mem[0] = ent(1'b1, 1'b0, 2'd1, 1'b0, 7'h05, 8'hA5);
        clear_logs();
        pulse_start();
        wait_done("single_write");
        checks++;
        if (frame_log.size() != 1 || frame_log[0] !== 16'h05A5) begin
            errors++;
            $display("FAIL write_frame: got %0d frames first=%h, expected 1 frame 05a5",
                     frame_log.size(), (frame_log.size() > 0) ? frame_log[0] : 16'hxxxx);
        end
        checks++;
        if (sel_log.size() != 1 || sel_log[0] !== 2'd1) begin
            errors++;
            $display("FAIL write_sel: got %0d entries, expected sel 1 in frame", sel_log.size());
        end
        checks++;
        if (edge_log.size() != 1 || edge_log[0] != 32) begin
            errors++;
            $display("FAIL write_edges: got %0d, expected 32", (edge_log.size() > 0) ? edge_log[0] : -1);
        end
        checks++;
        if (lead_log != 3 || low_log != 99) begin
            errors++;
            $display("FAIL write_timing: got lead=%0d low=%0d, expected lead=3 low=99", lead_log, low_log);
        end
        checks++;
        if (done_cnt != 1 || err !== 1'b0 || busy !== 1'b0 || spi_sel !== 2'd0) begin
            errors++;
            $display("FAIL write_status: got done_cnt=%0d err=%b busy=%b sel=%0d, expected 1 0 0 0",
                     done_cnt, err, busy, spi_sel);
        end
        checks++;
        if (mosi_viol != 0) begin
            errors++;
            $display("FAIL write_mosi_mode0: got %0d changes off falling sck, expected 0", mosi_viol);
        end
    endtask

    task automatic test_read_verify();
        tbl_mem[0] = ent(1'b1, 1'b1, 2'd1, 1'b1, 7'h07, 8'h3C);
        clear_logs();
        pulse_start();
        wait_done("read_ok");
        checks++;
        if (last_rd !== 8'h3C || rv_cnt != 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL read_ok: got rd=%h valid_cnt=%0d err=%b, expected 3c 1 0", last_rd, rv_cnt, err);
        end
        checks++;
        if (frame_log.size() != 1 || frame_log[0] !== 16'h8700) begin
            errors++;
            $display("FAIL read_frame: got %0d frames, expected 1 frame 8700", frame_log.size());
        end
        tbl_mem[0] = ent(1'b1, 1'b1, 2'd1, 1'b1, 7'h07, 8'h3D);
        clear_logs();
        pulse_start();
        wait_done("read_bad");
        repeat (20) @(negedge clk);
        checks++;
        if (err !== 1'b1 || rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL read_mismatch_err: got err=%b rd=%h, expected 1 3c", err, rd_data);
        end
        tbl_mem[0] = ent(1'b1, 1'b1, 2'd1, 1'b1, 7'h07, 8'h3C);
        pulse_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear_on_start: got err=%b busy=%b, expected 0 1", err, busy);
        end
        wait_done("read_again");
    endtask

    task automatic load_three();
        tbl_mem[0] = ent(1'b0, 1'b0, 2'd1, 1'b0, 7'h10, 8'h11);
        tbl_mem[1] = ent(1'b0, 1'b0, 2'd2, 1'b0, 7'h20, 8'h22);
        tbl_mem[2] = ent(1'b1, 1'b0, 2'd3, 1'b0, 7'h30, 8'h33);
    endtask

    task automatic test_three_entries();
        load_three();
        clear_logs();
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        pulse_start();
        repeat (150) @(negedge clk);
        pulse_start();
        wait_done("three");
        checks++;
        if (frame_log.size() != 3 || frame_log[0] !== 16'h1011 ||
            frame_log[1] !== 16'h2022 || frame_log[2] !== 16'h3033) begin
            errors++;
            $display("FAIL three_frames: got %0d frames, expected 1011 2022 3033", frame_log.size());
        end
        checks++;
        if (sel_log.size() != 3 || sel_log[0] !== 2'd1 || sel_log[1] !== 2'd2 || sel_log[2] !== 2'd3) begin
            errors++;
            $display("FAIL three_sels: got %0d entries, expected sels 1 2 3", sel_log.size());
        end
        checks++;
        if (min_gap < 4 || sel_viol != 0) begin
            errors++;
            $display("FAIL three_gap_sel: got min_gap=%0d sel_viol=%0d, expected >=4 and 0", min_gap, sel_viol);
        end
        checks++;
        if (done_cnt != 1 || spi_sel !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL three_end: got done_cnt=%0d sel=%0d busy=%b, expected 1 0 0", done_cnt, spi_sel, busy);
        end
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        load_three();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_csn === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_frame_start: got no csn low, expected frame start within 50 cycles");
        end
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        wait_done("abort");
        repeat (150) @(negedge clk);
        checks++;
        if (frame_log.size() != 1 || edge_log.size() != 1 || edge_log[0] != 32) begin
            errors++;
            $display("FAIL abort_frames: got %0d frames, expected 1 frame with 32 edges", frame_log.size());
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_end: got done_cnt=%0d busy=%b, expected 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        load_three();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rise_cnt == 9 && m_csn === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_reach: got no bit 9, expected within 200 cycles");
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_csn !== 1'b1 || m_sck !== 1'b0 || spi_sel !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got csn=%b sck=%b sel=%0d busy=%b, expected 1 0 0 0",
                     m_csn, m_sck, spi_sel, busy);
        end
        repeat (2) @(negedge clk);
        clear_logs();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("after_reset");
        checks++;
        if (frame_log.size() != 3 || frame_log[0] !== 16'h1011 || sel_log.size() == 0 || sel_log[0] !== 2'd1) begin
            errors++;
            $display("FAIL reset_restart: got %0d frames, expected 3 starting 1011 sel 1", frame_log.size());
        end
    endtask

    task automatic test_no_last();
        tbl2_mem[0] = ent(1'b0, 1'b0, 2'd2, 1'b0, 7'h01, 8'h01);
        tbl2_mem[1] = ent(1'b0, 1'b0, 2'd2, 1'b0, 7'h02, 8'h02);
        tbl2_mem[2] = ent(1'b0, 1'b0, 2'd2, 1'b0, 7'h03, 8'h03);
        tbl2_mem[3] = ent(1'b0, 1'b0, 2'd2, 1'b0, 7'h04, 8'h04);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done2 === 1'b1) break;
        end
        repeat (200) @(negedge clk);
        checks++;
        if (frames2 != 4 || done2_cnt != 1) begin
            errors++;
            $display("FAIL no_last_frames: got frames=%0d done=%0d, expected 4 1", frames2, done2_cnt);
        end
        checks++;
        if (wrap2 != 0 || addr2_at_done !== 2'd3 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL no_last_addr: got wrap=%0d addr=%0d busy=%b, expected 0 3 0",
                     wrap2, addr2_at_done, busy2);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tbl_mem[i] = '0;
        for (int i = 0; i < 4; i++) tbl2_mem[i] = '0;
        test_reset();
        repeat (2) @(negedge clk);
        test_single_write();
        test_read_verify();
        test_three_entries();
        test_abort();
        test_reset_mid();
        test_no_last();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
